// File: rtl/sram_mem_ctrl.sv
// MEM-stage controller: splits 32-bit loads/stores into two 16-bit SRAM half-accesses, freezing the pipeline meanwhile.
// Optional SRAM_MEM_CTRL_ADDR_CHECK_EN adds out-of-window detection with a sticky addr_err output.
module sram_mem_ctrl #(
    parameter int WORD_WIDTH      = 32,
    parameter int SRAM_ADDR_WIDTH = 18,
    parameter int WAIT_CYCLES     = 4,
    parameter int BASE_ADDR       = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       mem_read,
    input  logic                       mem_write,
    input  logic [WORD_WIDTH-1:0]      addr,
    input  logic [WORD_WIDTH-1:0]      wdata,
    output logic [WORD_WIDTH-1:0]      rdata,
    output logic                       ready,
    output logic                       freeze,
    output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
    output logic [15:0]                sram_dq_out,
    output logic                       sram_dq_oe,
    input  logic [15:0]                sram_dq_in,
    output logic                       sram_we_n
`ifdef SRAM_MEM_CTRL_ADDR_CHECK_EN
    ,
    output logic                       addr_err
`endif
);

    localparam int WA_W = SRAM_ADDR_WIDTH - 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LO   = 2'd1;
    localparam logic [1:0] HI   = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  wr_q, wr_d;
    logic [WA_W-1:0]       wa_q, wa_d;
    logic [WORD_WIDTH-1:0] wd_q, wd_d;
    logic [WORD_WIDTH-1:0] rdata_q, rdata_d;
    logic                  req;
    logic                  last;

    assign req  = mem_read | mem_write;
    assign last = (cnt_q == 4'(WAIT_CYCLES - 1));

`ifdef SRAM_MEM_CTRL_ADDR_CHECK_EN
    localparam int AW1 = WORD_WIDTH + 1;
    localparam logic [AW1-1:0] LIMIT = AW1'(BASE_ADDR) + (AW1'(1) << (SRAM_ADDR_WIDTH + 1));
    logic err_q, err_d;
    logic oob;
    assign oob      = (addr < WORD_WIDTH'(BASE_ADDR)) || ({1'b0, addr} >= LIMIT);
    assign addr_err = err_q;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        wa_d    = wa_q;
        wd_d    = wd_q;
        rdata_d = rdata_q;
`ifdef SRAM_MEM_CTRL_ADDR_CHECK_EN
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (req) begin
                    // a simultaneous read+write is serviced as a read
                    wr_d  = mem_write & ~mem_read;
                    wa_d  = WA_W'((addr - WORD_WIDTH'(BASE_ADDR)) >> 2);
                    wd_d  = wdata;
                    cnt_d = 4'd0;
`ifdef SRAM_MEM_CTRL_ADDR_CHECK_EN
                    if (oob) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                        if (mem_read) rdata_d = '0;
                    end else begin
                        state_d = LO;
                    end
`else
                    state_d = LO;
`endif
                end
            end
            LO: begin
                if (last) begin
                    state_d = HI;
                    cnt_d   = 4'd0;
                    if (!wr_q) rdata_d[15:0] = sram_dq_in;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            HI: begin
                if (last) begin
                    state_d = DONE;
                    cnt_d   = 4'd0;
                    if (!wr_q) rdata_d[31:16] = sram_dq_in;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            wa_q    <= '0;
            wd_q    <= '0;
            rdata_q <= '0;
`ifdef SRAM_MEM_CTRL_ADDR_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            wa_q    <= wa_d;
            wd_q    <= wd_d;
            rdata_q <= rdata_d;
`ifdef SRAM_MEM_CTRL_ADDR_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    always_comb begin
        sram_addr   = '0;
        sram_dq_out = 16'h0;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;
        if (state_q == LO || state_q == HI) begin
            sram_addr = {wa_q, state_q == HI};
            if (wr_q) begin
                sram_we_n   = 1'b0;
                sram_dq_oe  = 1'b1;
                sram_dq_out = (state_q == HI) ? wd_q[31:16] : wd_q[15:0];
            end
        end
    end

    assign ready  = ((state_q == IDLE) && !req) || (state_q == DONE);
    assign freeze = ~ready;
    assign rdata  = rdata_q;

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Randomized bench for sram_mem_ctrl against a word-level memory model and a behavioural 16-bit SRAM.
module tb_sram_mem_ctrl;
    localparam int W    = 4;
    localparam int BASE = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write;
    logic [31:0] addr, wdata, rdata;
    logic        ready, freeze;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out, sram_dq_in;
    logic        sram_dq_oe, sram_we_n;
`ifdef SRAM_MEM_CTRL_ADDR_CHECK_EN
    logic        addr_err;
`endif

    logic [15:0] sram   [0:1023];
    logic [31:0] refmem [0:255];
    logic [31:0] last_rd;
    bit          err_exp;
    int          nchk = 0;
    int          nerr = 0;

    always #5 clk = ~clk;
    assign sram_dq_in = sram[sram_addr[9:0]];

    sram_mem_ctrl #(.WORD_WIDTH(32), .SRAM_ADDR_WIDTH(18), .WAIT_CYCLES(W), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready), .freeze(freeze),
        .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
        .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n)
`ifdef SRAM_MEM_CTRL_ADDR_CHECK_EN
        , .addr_err(addr_err)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            mem_read = 1'b0; mem_write = 1'b0;
            #1;
            chk("idle_ready", {ready, freeze}, 2'b10);
        end
    endtask

    task automatic access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd);
        int cyc, bad, wi;
        bit inr, isw, lohi, ew;
        logic [17:0] ea;
        logic [15:0] ed;
        logic [31:0] exp;
        inr = (a >= BASE) && ({1'b0, a} < 33'(BASE) + 33'(2**19));
        isw = wr && !rd;
        wi  = inr ? int'((a - BASE) >> 2) : 0;
        @(negedge clk);
        mem_read = rd; mem_write = wr; addr = a; wdata = wd;
        #1;
        cyc = 0; bad = 0;
        while (freeze && cyc < 64) begin
            lohi = inr && cyc >= 1 && cyc <= 2 * W;
            ew   = lohi && isw;
            ea   = lohi ? 18'(2 * wi + ((cyc > W) ? 1 : 0)) : 18'h0;
            ed   = ew ? ((cyc > W) ? wd[31:16] : wd[15:0]) : 16'h0;
            if (sram_addr !== ea || sram_dq_out !== ed || sram_we_n !== !ew ||
                sram_dq_oe !== ew || ready !== 1'b0) bad++;
            if (!sram_we_n) sram[sram_addr[9:0]] = sram_dq_out;
            cyc++;
            @(negedge clk);
            #1;
        end
        chk("latency", cyc, inr ? 2 * W + 1 : 1);
        chk("sram_seq", bad, 0);
        chk("done_ready", {ready, freeze}, 2'b10);
        chk("done_quiet", {sram_addr, sram_we_n, sram_dq_oe}, {18'h0, 1'b1, 1'b0});
        if (!inr)    exp = rd ? 32'h0 : last_rd;
        else if (rd) exp = refmem[wi];
        else         exp = last_rd;
        if (inr && isw) refmem[wi] = wd;
        chk("rdata", rdata, exp);
        last_rd = exp;
`ifdef SRAM_MEM_CTRL_ADDR_CHECK_EN
        if (!inr) err_exp = 1'b1;
        chk("addr_err", addr_err, err_exp);
`endif
    endtask

    task automatic reset_in_hi();
        bit pulsed;
        pulsed = 1'b0;
        @(negedge clk);
        mem_read = 1'b1; mem_write = 1'b0; addr = BASE + 8;
        #1;
        repeat (W + 2) begin
            if (ready) pulsed = 1'b1;
            @(negedge clk);
            #1;
        end
        if (ready) pulsed = 1'b1;
        rst = 1'b0; mem_read = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_no_ready", pulsed, 0);
        chk("abort_state", {ready, freeze, sram_we_n, sram_dq_oe}, 4'b1010);
        chk("abort_addr", sram_addr, 0);
        chk("abort_rdata", rdata, 0);
        last_rd = 32'h0;
        err_exp = 1'b0;
`ifdef SRAM_MEM_CTRL_ADDR_CHECK_EN
        chk("abort_err_clr", addr_err, 0);
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1);
    end

    initial begin
        int op;
        logic [31:0] a;
        rst = 1'b0; mem_read = 1'b0; mem_write = 1'b0; addr = '0; wdata = '0;
        last_rd = 32'h0; err_exp = 1'b0;
        for (int i = 0; i < 256; i++) begin
            refmem[i] = $urandom;
            sram[2 * i]     = refmem[i][15:0];
            sram[2 * i + 1] = refmem[i][31:16];
        end
        for (int i = 512; i < 1024; i++) sram[i] = 16'h0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", {ready, freeze}, 2'b10);
        chk("rst_sram", {sram_we_n, sram_dq_oe}, 2'b10);
        chk("rst_rdata", rdata, 0);
        rst = 1'b1;

        access(1'b0, 1'b1, BASE + 4, 32'hDEADBEEF);
        idle(1);
        access(1'b1, 1'b0, BASE + 4, 32'h0);
        chk("read_deadbeef", rdata, 32'hDEADBEEF);
        idle(1);
        access(1'b1, 1'b1, BASE + 4, 32'h12345678);
        chk("rdwr_is_read", rdata, 32'hDEADBEEF);
        access(1'b1, 1'b0, BASE + 4, 32'h0);
        access(1'b0, 1'b1, BASE + 8, 32'hCAFEF00D);
        access(1'b1, 1'b0, BASE + 8, 32'h0);
        chk("b2b_readback", rdata, 32'hCAFEF00D);
        reset_in_hi();
        idle(1);

`ifdef SRAM_MEM_CTRL_ADDR_CHECK_EN
        access(1'b1, 1'b0, 32'h10, 32'h0);
        access(1'b1, 1'b0, BASE + 4, 32'h0);
        access(1'b0, 1'b1, BASE + 2**19, 32'h1);
`endif

        for (int n = 0; n < 200; n++) begin
            op = $urandom_range(0, 2);
            a  = BASE + 4 * $urandom_range(0, 255) + $urandom_range(0, 3);
`ifdef SRAM_MEM_CTRL_ADDR_CHECK_EN
            if ($urandom_range(0, 9) == 0)
                a = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, BASE - 1))
                                                : 32'(BASE + 2**19) + $urandom_range(0, 4096);
`endif
            access(op != 1, op != 0, a, $urandom);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end

        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end
endmodule

// File: doc/sram_mem_ctrl.md
Name: sram_mem_ctrl

Overview:
- Multi-cycle controller for the MEM stage. It sits between the EXE/MEM pipeline register outputs (mem_read, mem_write, ALU result as address, val_Rm as store data) and an external 16-bit asynchronous SRAM.
- Splits each 32-bit access into low/high 16-bit half-accesses with programmable wait states.
- Drives freeze to every pipeline register until the access completes.

Parameters:
- WORD_WIDTH, 32, CPU data/address width
- SRAM_ADDR_WIDTH, 18, SRAM half-word address width
- WAIT_CYCLES, 4, cycles held per half-access (legal range 1..15)
- BASE_ADDR, 1024, byte address mapped to SRAM half-word 0

Ports:
- clk  in  1  clock, all state on posedge
- rst  in  1  synchronous reset, active-low; one clock; reset is synchronous and active-low
- mem_read  in  1  load request, held stable while freeze=1
- mem_write  in  1  store request, held stable while freeze=1
- addr  in  WORD_WIDTH  byte address (ALU result)
- wdata  in  WORD_WIDTH  store data (val_Rm)
- rdata  out  WORD_WIDTH  load data to MEM/WB register
- ready  out  1  access complete / controller free
- freeze  out  1  stall to all pipeline registers, equals ~ready
- sram_addr  out  SRAM_ADDR_WIDTH  SRAM half-word address
- sram_dq_out  out  16  SRAM write data
- sram_dq_oe  out  1  drive sram_dq_out onto bus
- sram_dq_in  in  16  SRAM read data
- sram_we_n  out  1  SRAM write enable, active-low

Behaviour:
- States: IDLE, LO, HI, DONE. The counter cnt is 4 bits wide.
- Reset: on a posedge with rst=0, state becomes IDLE, cnt becomes 0, and rdata becomes 0. Mid-operation reset has priority over everything. The access is abandoned, and DONE is never reached for it.
- In IDLE:
  - ready=1 if neither mem_read nor mem_write is asserted, else ready=0.
  - A request moves the state to LO with cnt=0 and latches op and word_addr.
  - word_addr = (addr - BASE_ADDR) >> 2, truncated to SRAM_ADDR_WIDTH-1 bits.
  - If mem_read and mem_write are both 1, the access is treated as a read and the write is ignored.
- In LO:
  - sram_addr = {word_addr, 0}.
  - cnt increments each cycle. When cnt == WAIT_CYCLES-1, the state moves to HI and cnt resets to 0.
  - For a read, sram_dq_in is captured into rdata[15:0] on that last cycle.
- In HI:
  - sram_addr = {word_addr, 1}.
  - Same counting as LO, then the state moves to DONE.
  - For a read, rdata[31:16] is captured on the last cycle.
- In DONE:
  - ready=1 for exactly one cycle, during which the pipeline advances.
  - The state moves to IDLE unconditionally.
- Writes: in LO/HI, sram_we_n=0 and sram_dq_oe=1. sram_dq_out = wdata[15:0] in LO and wdata[31:16] in HI.
- Defaults in all other states and for reads: sram_we_n=1, sram_dq_oe=0, sram_dq_out=0.
- SRAM outputs are combinational from state and latched registers. sram_addr is 0 in IDLE and DONE.
- Latency: the IDLE request cycle plus 2*WAIT_CYCLES cycles have freeze=1. ready rises in the following cycle.
- rdata holds its last captured value between reads and is unchanged by writes.
- Back-to-back: the request after DONE is sampled in IDLE on the next cycle. There is no bubble beyond the IDLE cycle.
- wdata and addr are latched at IDLE exit. Later input changes do not affect the in-flight access.

Optional Feature:
- Macro: SRAM_MEM_CTRL_ADDR_CHECK_EN.
- With the macro defined:
  - Extra port addr_err (out, 1), sticky until reset.
  - A request with addr < BASE_ADDR, or addr >= BASE_ADDR + 2^(SRAM_ADDR_WIDTH+1), goes IDLE->DONE directly with no SRAM activity.
  - For such a request, rdata is set to 0 if it is a read, and addr_err is set.
  - freeze is high for 1 cycle only.
- Without the macro: there is no addr_err port, and the address is truncated silently.

Test Plan:
- Reset: hold rst=0 for 2 cycles with no requests -> ready=1, freeze=0, sram_we_n=1, sram_dq_oe=0, rdata=0.
- Write: addr=1028, wdata=0xDEADBEEF, WAIT_CYCLES=4 -> freeze=1 for 9 cycles.
  - sram_addr=2, dq_out=0xBEEF, we_n=0 for 4 cycles.
  - Then sram_addr=3, dq_out=0xDEAD for 4 cycles.
  - ready=1 on cycle 10.
- Read: addr=1028 with the SRAM model returning 0xBEEF at half 2 and 0xDEAD at half 3 -> rdata=0xDEADBEEF when ready=1. we_n stays 1 throughout.
- Simultaneous request: mem_read=mem_write=1 -> read sequence only, we_n never 0.
- Back-to-back and reset:
  - A read followed immediately by a write to 1032 -> second access starts with sram_addr=4, freeze low only during the DONE cycle.
  - Separately, a reset pulse during HI -> state IDLE, we_n=1 on the next cycle, rdata=0, ready never pulses.
- Macro on: addr=0x10 read -> freeze high 1 cycle, rdata=0, addr_err=1 and held through subsequent valid accesses until reset.
